// File: rtl/dcache_ctrl_if.sv
// CPU-side access channel of the data cache.
// The CPU data-access stage is the master, dcache_ctrl is the slave.
interface dcache_ctrl_if;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready
    );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Serves 16-bit CPU word accesses from LINE_NUMBER lines of LINE_SIZE words and
// moves whole lines over the 64-bit memory port 2 (readM2/writeM2/address2/data2).
// Hits complete in the same cycle; misses write back a dirty victim, refill the
// line and answer the CPU one cycle after the refill completes.
// Optional build macro DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module dcache_ctrl #(
    parameter int LINE_NUMBER = 8,
    parameter int LINE_SIZE   = 4,
    parameter int TAG_SIZE    = 11,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    dcache_ctrl_if.slave             cpu,
    output logic                     readM2,
    output logic                     writeM2,
    output logic [15:0]              address2,
    inout  wire  [LINE_SIZE*16-1:0]  data2,
    input  logic                     M2busy,
    output logic                     mem_err
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]              hit_count,
    output logic [15:0]              miss_count
`endif
);

    localparam int IDX_W  = $clog2(LINE_NUMBER);
    localparam int OFF_W  = $clog2(LINE_SIZE);
    localparam int LINE_W = LINE_SIZE * 16;
    localparam int TCNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        RESP
    } state_t;

    state_t state;

    logic [LINE_W-1:0]    line_data [LINE_NUMBER];
    logic [TAG_SIZE-1:0]  tag_mem   [LINE_NUMBER];
    logic [LINE_NUMBER-1:0] valid;
    logic [LINE_NUMBER-1:0] dirty;

    logic [LINE_W-1:0]    wb_line;
    logic [TCNT_W-1:0]    tcnt;
    logic                 seen_busy;

    logic [TAG_SIZE-1:0]  addr_tag;
    logic [IDX_W-1:0]     idx;
    logic [OFF_W-1:0]     off;
    logic [LINE_W-1:0]    cur_line;
    logic [LINE_W-1:0]    merged_line;
    logic [15:0]          fill_addr;
    logic                 access;
    logic                 hit;
    logic                 xfer_done;
    logic                 timeout;

    // Word 0 of a line sits in the most significant 16 bits.
    function automatic logic [15:0] get_word(input logic [LINE_W-1:0] line,
                                             input logic [OFF_W-1:0]  o);
        get_word = line[(LINE_SIZE - 1 - int'(o)) * 16 +: 16];
    endfunction

    function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  o,
                                                   input logic [15:0]       w);
        logic [LINE_W-1:0] r;
        r = line;
        r[(LINE_SIZE - 1 - int'(o)) * 16 +: 16] = w;
        put_word = r;
    endfunction

    assign addr_tag    = cpu.cpu_addr[15 -: TAG_SIZE];
    assign idx         = cpu.cpu_addr[OFF_W +: IDX_W];
    assign off         = cpu.cpu_addr[OFF_W-1:0];
    assign fill_addr   = {cpu.cpu_addr[15:OFF_W], {OFF_W{1'b0}}};
    assign cur_line    = line_data[idx];
    assign merged_line = put_word(cur_line, off, cpu.cpu_wdata);

    assign access    = cpu.cpu_read | cpu.cpu_write;
    assign hit       = valid[idx] && (tag_mem[idx] == addr_tag) && access;
    assign xfer_done = seen_busy && !M2busy;
    assign timeout   = (tcnt == TCNT_W'(MEM_TIMEOUT - 1));

    // Hits answer combinationally; a miss answers only in the single RESP cycle.
    assign cpu.cpu_ready = ((state == IDLE) && hit) || (state == RESP);
    assign cpu.cpu_rdata = get_word(cur_line, off);

    // The victim line is only put on the shared bus while a writeback is requested.
    assign data2 = writeM2 ? wb_line : {LINE_W{1'bz}};

    // Main controller: lookup/update in IDLE, writeback, refill, response and timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            readM2    <= 1'b0;
            writeM2   <= 1'b0;
            address2  <= '0;
            wb_line   <= '0;
            tcnt      <= '0;
            seen_busy <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        if (cpu.cpu_write) begin
                            line_data[idx] <= merged_line;
                            dirty[idx]     <= 1'b1;
                        end
                    end else if (access) begin
                        tcnt      <= '0;
                        seen_busy <= 1'b0;
                        if (valid[idx] && dirty[idx]) begin
                            writeM2  <= 1'b1;
                            address2 <= {tag_mem[idx], idx, {OFF_W{1'b0}}};
                            wb_line  <= cur_line;
                            state    <= WB;
                        end else begin
                            readM2   <= 1'b1;
                            address2 <= fill_addr;
                            state    <= FILL;
                        end
                    end
                end

                WB: begin
                    if (xfer_done) begin
                        writeM2    <= 1'b0;
                        dirty[idx] <= 1'b0;
                        readM2     <= 1'b1;
                        address2   <= fill_addr;
                        tcnt       <= '0;
                        seen_busy  <= 1'b0;
                        state      <= FILL;
                    end else if (timeout) begin
                        writeM2 <= 1'b0;
                        mem_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                        if (M2busy) begin
                            seen_busy <= 1'b1;
                        end
                    end
                end

                FILL: begin
                    if (xfer_done) begin
                        line_data[idx] <= data2;
                        tag_mem[idx]   <= addr_tag;
                        valid[idx]     <= 1'b1;
                        dirty[idx]     <= 1'b0;
                        readM2         <= 1'b0;
                        state          <= RESP;
                    end else if (timeout) begin
                        readM2  <= 1'b0;
                        mem_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                        if (M2busy) begin
                            seen_busy <= 1'b1;
                        end
                    end
                end

                RESP: begin
                    if (cpu.cpu_write) begin
                        line_data[idx] <= merged_line;
                        dirty[idx]     <= 1'b1;
                    end
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // Saturating counters of IDLE hits and of misses that leave IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if ((state == IDLE) && hit && (hit_count != 16'hffff)) begin
                hit_count <= hit_count + 16'd1;
            end
            if ((state == IDLE) && access && !hit && (miss_count != 16'hffff)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed testbench for dcache_ctrl with a small line-based memory model on port 2.
// Memory answers each new request with M2busy high for MEM_LAT cycles; a stuck mode
// holds M2busy high to exercise the transfer timeout.
module tb_dcache_ctrl;

    localparam int MEM_LAT = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        readM2;
    logic        writeM2;
    logic [15:0] address2;
    wire  [63:0] data2;
    logic        M2busy = 1'b0;
    logic        mem_err;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    dcache_ctrl_if cpu_bus ();

    dcache_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .cpu      (cpu_bus.slave),
        .readM2   (readM2),
        .writeM2  (writeM2),
        .address2 (address2),
        .data2    (data2),
        .M2busy   (M2busy),
        .mem_err  (mem_err)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Memory model state
    logic [63:0] mem [0:255];
    int          mem_cnt  = 0;
    logic [1:0]  mem_kind = 2'd0;
    logic [1:0]  cur_kind;
    logic        stuck    = 1'b0;
    int          mem_reads  = 0;
    int          mem_writes = 0;
    logic [15:0] last_wr_addr = '0;
    logic [63:0] last_wr_data = '0;

    // Bus monitor state
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    int          both_cnt  = 0;
    logic [15:0] rd_addr   = '0;

    // 10 ns clock
    always #5 clk = ~clk;

    assign cur_kind = writeM2 ? 2'd2 : (readM2 ? 2'd1 : 2'd0);
    assign data2    = (readM2 && !writeM2) ? mem[address2[9:2]] : 64'hz;

    // Memory: start a transfer on a new request kind, hold busy, then complete.
    always @(posedge clk) begin
        if (stuck) begin
            if (readM2 || writeM2) M2busy <= 1'b1;
        end else if (M2busy) begin
            if (mem_cnt <= 1) begin
                M2busy   <= 1'b0;
                mem_kind <= cur_kind;
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end else if ((readM2 || writeM2) && (mem_kind != cur_kind)) begin
            M2busy  <= 1'b1;
            mem_cnt <= MEM_LAT;
            if (writeM2) begin
                mem[address2[9:2]] <= data2;
                mem_writes   <= mem_writes + 1;
                last_wr_addr <= address2;
                last_wr_data <= data2;
            end else begin
                mem_reads <= mem_reads + 1;
            end
        end else if (!(readM2 || writeM2)) begin
            mem_kind <= 2'd0;
        end
    end

    // Monitor request activity away from the active edge.
    always @(negedge clk) begin
        if (readM2) begin
            rd_cycles = rd_cycles + 1;
            rd_addr   = address2;
        end
        if (writeM2) wr_cycles = wr_cycles + 1;
        if (readM2 && writeM2) both_cnt = both_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                 input logic [15:0] wdata);
        cpu_bus.cpu_read  = rd;
        cpu_bus.cpu_write = wr;
        cpu_bus.cpu_addr  = addr;
        cpu_bus.cpu_wdata = wdata;
    endtask

    task automatic clearMon();
        rd_cycles = 0;
        wr_cycles = 0;
        rd_addr   = '0;
    endtask

    // One CPU access: wait (bounded) for cpu_ready and check latency and load data.
    task automatic cpuAccess(input string tag, input logic rd, input logic wr,
                             input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [15:0] exp_rdata, input int exp_lat);
        int          lat;
        logic        rdy;
        logic [15:0] rdata;
        @(negedge clk);
        #1;
        clearMon();
        applyStimulus(rd, wr, addr, wdata);
        #1;
        lat = 0;
        while (!cpu_bus.cpu_ready && lat < 60) begin
            @(negedge clk);
            #1;
            lat = lat + 1;
        end
        rdy   = cpu_bus.cpu_ready;
        rdata = cpu_bus.cpu_rdata;
        checkOutput({tag, "_ready"}, 64'(rdy), 64'd1);
        checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        if (rd) checkOutput({tag, "_rdata"}, 64'(rdata), 64'(exp_rdata));
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 64'h0;
        mem[8'd8]  = 64'h0000_0000_0000_6000;
        mem[8'd16] = 64'h1111_2222_3333_4444;
        mem[8'd41] = 64'hAAAA_BBBB_CCCC_DDDD;
        mem[8'd49] = 64'h5555_6666_7777_8888;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        reset = 1'b1;

        $display("[TB] reset state");
        doReset();
        checkOutput("rst_readM2", 64'(readM2), 64'd0);
        checkOutput("rst_writeM2", 64'(writeM2), 64'd0);
        checkOutput("rst_ready", 64'(cpu_bus.cpu_ready), 64'd0);
        checkOutput("rst_mem_err", 64'(mem_err), 64'd0);

        $display("[TB] cold read miss");
        cpuAccess("cold", 1'b1, 1'b0, 16'h0023, 16'h0, 16'h6000, 9);
        checkOutput("cold_addr", 64'(rd_addr), 64'h0020);
        checkOutput("cold_rd_cycles", 64'(rd_cycles), 64'd8);
        checkOutput("cold_wr_cycles", 64'(wr_cycles), 64'd0);
        checkOutput("cold_mem_reads", 64'(mem_reads), 64'd1);

        $display("[TB] read hit");
        cpuAccess("hit", 1'b1, 1'b0, 16'h0021, 16'h0, 16'h0000, 0);
        checkOutput("hit_rd_cycles", 64'(rd_cycles), 64'd0);

        $display("[TB] write hit then conflicting read");
        cpuAccess("whit", 1'b0, 1'b1, 16'h0022, 16'h1234, 16'h0, 0);
        cpuAccess("conf", 1'b1, 1'b0, 16'h0042, 16'h0, 16'h3333, 17);
        checkOutput("conf_mem_writes", 64'(mem_writes), 64'd1);
        checkOutput("conf_wb_addr", 64'(last_wr_addr), 64'h0020);
        checkOutput("conf_wb_data", last_wr_data, 64'h0000_0000_1234_6000);
        checkOutput("conf_fill_addr", 64'(rd_addr), 64'h0040);
        checkOutput("conf_wr_cycles", 64'(wr_cycles), 64'd8);
        checkOutput("conf_rd_cycles", 64'(rd_cycles), 64'd8);
        checkOutput("conf_mem_word", 64'(mem[8'd8][31:16]), 64'h1234);
        cpuAccess("readback", 1'b1, 1'b0, 16'h0022, 16'h0, 16'h1234, 9);
        checkOutput("readback_wr_cycles", 64'(wr_cycles), 64'd0);
`ifdef DCACHE_STATS_EN
        checkOutput("stats_hits", 64'(hit_count), 64'd2);
        checkOutput("stats_misses", 64'(miss_count), 64'd3);
`endif

        $display("[TB] write miss with clean victim");
        cpuAccess("wmiss", 1'b0, 1'b1, 16'h00A5, 16'hBEEF, 16'h0, 9);
        checkOutput("wmiss_fill_addr", 64'(rd_addr), 64'h00A4);
        checkOutput("wmiss_wr_cycles", 64'(wr_cycles), 64'd0);
        cpuAccess("wmiss_rd1", 1'b1, 1'b0, 16'h00A5, 16'h0, 16'hBEEF, 0);
        cpuAccess("wmiss_rd2", 1'b1, 1'b0, 16'h00A6, 16'h0, 16'hCCCC, 0);
        cpuAccess("conf2", 1'b1, 1'b0, 16'h00C5, 16'h0, 16'h6666, 17);
        checkOutput("conf2_wb_addr", 64'(last_wr_addr), 64'h00A4);
        checkOutput("conf2_wb_data", last_wr_data, 64'hAAAA_BEEF_CCCC_DDDD);
        checkOutput("conf2_fill_addr", 64'(rd_addr), 64'h00C4);

        $display("[TB] reset during refill");
        @(negedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 16'h0063, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstfill_pre_readM2", 64'(readM2), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstfill_readM2", 64'(readM2), 64'd0);
        checkOutput("rstfill_ready", 64'(cpu_bus.cpu_ready), 64'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        cpuAccess("postrst", 1'b1, 1'b0, 16'h0023, 16'h0, 16'h6000, 9);
        checkOutput("postrst_fill_addr", 64'(rd_addr), 64'h0020);

        $display("[TB] memory timeout");
        stuck = 1'b1;
        @(negedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 16'h0083, 16'h0);
        @(negedge clk);
        n = 0;
        while (readM2 && n < 40) begin
            n = n + 1;
            @(negedge clk);
        end
        checkOutput("tmo_req_cycles", 64'(n), 64'd15);
        checkOutput("tmo_mem_err", 64'(mem_err), 64'd1);
        checkOutput("tmo_readM2", 64'(readM2), 64'd0);
        checkOutput("tmo_ready", 64'(cpu_bus.cpu_ready), 64'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0);
        stuck = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("tmo_idle_readM2", 64'(readM2), 64'd0);
        checkOutput("tmo_sticky", 64'(mem_err), 64'd1);
        doReset();
        checkOutput("tmo_cleared", 64'(mem_err), 64'd0);

        checkOutput("never_both_req", 64'(both_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
